// File: rtl/conv_rslt_pool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : conv_rslt_pool_pkg                                         |
// | Brief   : Shared widths, FSM encodings and saturating clamp helper   |
// |           for the convolution result / pooling stage.                |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package conv_rslt_pool_pkg;

  localparam int c_ACC_WIDTH  = 20;
  localparam int c_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clamp a shifted accumulator into the signed result range.
  // Returns {overflow, clamped_value}.
  function automatic logic [c_DATA_WIDTH:0] sat_clamp(
    input logic signed [c_ACC_WIDTH-1:0] v
  );
    logic signed [c_ACC_WIDTH-1:0] lim_hi;
    logic signed [c_ACC_WIDTH-1:0] lim_lo;
    lim_hi = c_ACC_WIDTH'((1 << (c_DATA_WIDTH - 1)) - 1);
    lim_lo = ~lim_hi;
    if (v > lim_hi) begin
      sat_clamp = {1'b1, lim_hi[c_DATA_WIDTH-1:0]};
    end else if (v < lim_lo) begin
      sat_clamp = {1'b1, lim_lo[c_DATA_WIDTH-1:0]};
    end else begin
      sat_clamp = {1'b0, v[c_DATA_WIDTH-1:0]};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_rslt_pool_requant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rslt_requant                                               |
// | Brief   : Arithmetic right shift + saturation of the accumulator,    |
// |           one registered stage.                                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rslt_requant
  import conv_rslt_pool_pkg::*;
#(
  parameter int ACC_WIDTH   = c_ACC_WIDTH,
  parameter int DATA_WIDTH  = c_DATA_WIDTH,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [ACC_WIDTH-1:0]   i_acc,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_ovf
);

  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH:0]         w_clamp;

  assign w_shifted = $signed(i_acc) >>> i_shift;
  assign w_clamp   = sat_clamp(w_shifted);

  // Register the clamped value; data only moves on a valid sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= i_valid;
      o_ovf   <= i_valid & w_clamp[DATA_WIDTH];
      if (i_valid) begin
        o_data <= w_clamp[DATA_WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_rslt_pool.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : conv_rslt_pool                                             |
// | Brief   : Requantise accumulator stream, optional ReLU and 1x2       |
// |           maxpool, generate result-BRAM writes and row markers.      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module conv_rslt_pool
  import conv_rslt_pool_pkg::*;
#(
  parameter int ACC_WIDTH   = c_ACC_WIDTH,
  parameter int DATA_WIDTH  = c_DATA_WIDTH,
  parameter int COL_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   acc_valid,
  input  logic [ACC_WIDTH-1:0]   acc_data,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   relu_en,
  input  logic                   pool_en,
  input  logic [COL_WIDTH-1:0]   result_cols,
  output logic                   rslt_we,
  output logic [DATA_WIDTH-1:0]  rslt_data,
  output logic                   row_done,
  output logic                   sat_flag,
  output logic                   busy
);

  state_t                        r_state;
  logic                          r_start_d;
  logic                          r_busy;
  logic                          r_drain_cnt;
  logic [SHIFT_WIDTH-1:0]        r_shift;
  logic                          r_relu;
  logic                          r_pool;
  logic [COL_WIDTH-1:0]          r_cols;
  logic [COL_WIDTH-1:0]          r_out_cnt;
  logic                          r_phase;
  logic signed [DATA_WIDTH-1:0]  r_held;
  logic                          r_we;
  logic [DATA_WIDTH-1:0]         r_data;
  logic                          r_row_done;
  logic                          r_sat;

  logic                          w_start_rise;
  logic                          w_launch;
  logic                          w_s1_valid;
  logic [DATA_WIDTH-1:0]         w_s1_data;
  logic                          w_s1_ovf;
  logic signed [DATA_WIDTH-1:0]  w_s2;
  logic                          w_do_write;
  logic                          w_hold;
  logic signed [DATA_WIDTH-1:0]  w_wr_val;

  assign w_start_rise = start & ~r_start_d;
  assign w_launch     = w_start_rise && (r_state == IDLE);

  rslt_requant #(
    .ACC_WIDTH   (ACC_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_requant (
    .clk     (clk),
    .reset   (reset),
    .i_valid (acc_valid && (r_state == RUN)),
    .i_acc   (acc_data),
    .i_shift (r_shift),
    .o_valid (w_s1_valid),
    .o_data  (w_s1_data),
    .o_ovf   (w_s1_ovf)
  );

  // ReLU on the requantised value.
  assign w_s2 = (r_relu && w_s1_data[DATA_WIDTH-1]) ? '0 : $signed(w_s1_data);

  // Pool decision: hold even samples, write max on odd, flush a lone half-pair in DRAIN.
  always_comb begin
    w_do_write = 1'b0;
    w_hold     = 1'b0;
    w_wr_val   = w_s2;
    if (w_s1_valid) begin
      if (!r_pool) begin
        w_do_write = 1'b1;
      end else if (!r_phase) begin
        w_hold = 1'b1;
      end else begin
        w_do_write = 1'b1;
        w_wr_val   = (r_held >= w_s2) ? r_held : w_s2;
      end
    end else if ((r_state == DRAIN) && r_phase) begin
      w_do_write = 1'b1;
      w_wr_val   = r_held;
    end
  end

  // Layer FSM and configuration latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_start_d   <= 1'b0;
      r_busy      <= 1'b0;
      r_drain_cnt <= 1'b0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_pool      <= 1'b0;
      r_cols      <= '0;
    end else begin
      r_start_d <= start;
      case (r_state)
        IDLE: begin
          if (w_start_rise) begin
            r_shift <= shift;
            r_relu  <= relu_en;
            r_pool  <= pool_en;
            r_cols  <= result_cols;
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!start) begin
            r_state     <= DRAIN;
            r_drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          // Stay at least two cycles; leave only once nothing is in flight or held.
          if (!r_drain_cnt) begin
            r_drain_cnt <= 1'b1;
          end else if (!w_s1_valid && !r_phase) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register, pair holder, column counter and sticky saturation flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_data     <= '0;
      r_row_done <= 1'b0;
      r_out_cnt  <= '0;
      r_phase    <= 1'b0;
      r_held     <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_row_done <= 1'b0;
      if (w_launch) begin
        r_sat     <= 1'b0;
        r_out_cnt <= '0;
        r_phase   <= 1'b0;
      end else begin
        if (w_s1_valid && w_s1_ovf) begin
          r_sat <= 1'b1;
        end
        if (w_hold) begin
          r_held  <= w_s2;
          r_phase <= 1'b1;
        end
        if (w_do_write) begin
          r_we    <= 1'b1;
          r_data  <= w_wr_val;
          r_phase <= 1'b0;
          if (r_out_cnt == r_cols) begin
            r_row_done <= 1'b1;
            r_out_cnt  <= '0;
          end else begin
            r_out_cnt <= r_out_cnt + COL_WIDTH'(1);
          end
        end
      end
    end
  end

  assign rslt_we   = r_we;
  assign rslt_data = r_data;
  assign row_done  = r_row_done;
  assign sat_flag  = r_sat;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_conv_rslt_pool.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_conv_rslt_pool                                          |
// | Brief   : Directed self-checking bench for conv_rslt_pool.           |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_conv_rslt_pool;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        acc_valid;
  logic [19:0] acc_data;
  logic [4:0]  shift;
  logic        relu_en;
  logic        pool_en;
  logic [7:0]  result_cols;
  logic        rslt_we;
  logic [7:0]  rslt_data;
  logic        row_done;
  logic        sat_flag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] r_wq[$];
  logic       r_rq[$];

  always #5 clk = ~clk;

  conv_rslt_pool dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .acc_valid   (acc_valid),
    .acc_data    (acc_data),
    .shift       (shift),
    .relu_en     (relu_en),
    .pool_en     (pool_en),
    .result_cols (result_cols),
    .rslt_we     (rslt_we),
    .rslt_data   (rslt_data),
    .row_done    (row_done),
    .sat_flag    (sat_flag),
    .busy        (busy)
  );

  // Capture every write with its row marker.
  always @(negedge clk) begin
    if (rslt_we) begin
      r_wq.push_back(rslt_data);
      r_rq.push_back(row_done);
    end
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    acc_valid = 1'b1;
    acc_data  = 20'(v);
    step();
    acc_valid = 1'b0;
  endtask

  // Config is sampled at the start rise; scramble it afterwards to prove it was latched.
  task automatic start_layer(input int sh, input logic relu, input logic pool, input int cols);
    shift       = 5'(sh);
    relu_en     = relu;
    pool_en     = pool;
    result_cols = 8'(cols);
    start       = 1'b1;
    step();
    shift       = 5'd7;
    relu_en     = ~relu;
    pool_en     = ~pool;
    result_cols = 8'd0;
  endtask

  task automatic end_layer(input string tag);
    int n;
    start = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      step();
      n++;
    end
    if (busy) check({tag, "_drain_timeout"}, 1, 0);
    step();
  endtask

  task automatic clear_q();
    r_wq.delete();
    r_rq.delete();
  endtask

  task automatic check_q(input string tag, input int n, input int d[8], input int r[8]);
    check({tag, "_count"}, r_wq.size(), n);
    for (int i = 0; i < n && i < r_wq.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), $signed(r_wq[i]), d[i]);
      check($sformatf("%s_row%0d", tag, i), 32'(r_rq[i]), r[i]);
    end
  endtask

  task automatic pass_through(input string tag);
    clear_q();
    start_layer(0, 1'b0, 1'b0, 3);
    check({tag, "_busy"}, 32'(busy), 1);
    send(5);
    send(-3);
    check({tag, "_lat_we"}, 32'(rslt_we), 1);
    check({tag, "_lat_data"}, $signed(rslt_data), 5);
    send(100);
    send(-128);
    step();
    step();
    end_layer(tag);
    check_q(tag, 4, '{5, -3, 100, -128, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});
    check({tag, "_sat"}, 32'(sat_flag), 0);
    check({tag, "_hold"}, $signed(rslt_data), -128);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; acc_valid = 1'b0; acc_data = '0;
    shift = '0; relu_en = 1'b0; pool_en = 1'b0; result_cols = '0;
    step();
    step();
    check("rst_we", 32'(rslt_we), 0);
    check("rst_data", $signed(rslt_data), 0);
    check("rst_row", 32'(row_done), 0);
    check("rst_sat", 32'(sat_flag), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    step();

    pass_through("pt");

    // Saturation and sticky flag.
    clear_q();
    start_layer(2, 1'b0, 1'b0, 3);
    send(1000);
    send(-1000);
    send(508);
    step();
    step();
    check_q("sat", 3, '{127, -128, 127, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    check("sat_set", 32'(sat_flag), 1);
    end_layer("sat");
    check("sat_sticky", 32'(sat_flag), 1);
    start_layer(0, 1'b0, 1'b0, 3);
    check("sat_clear", 32'(sat_flag), 0);
    end_layer("satclr");

    // ReLU + pool with a tie.
    clear_q();
    start_layer(0, 1'b1, 1'b1, 1);
    send(-7);
    send(4);
    send(9);
    send(9);
    step();
    step();
    end_layer("rp");
    check_q("rp", 2, '{4, 9, 0, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0, 0});

    // Flush of a held half-pair during DRAIN.
    clear_q();
    start_layer(0, 1'b0, 1'b1, 7);
    send(2);
    send(6);
    send(-1);
    end_layer("fl");
    check_q("fl", 2, '{6, -1, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    check("fl_busy", 32'(busy), 0);
    check("fl_hold", $signed(rslt_data), -1);

    // Gapped valids with row wrap every three writes.
    clear_q();
    start_layer(0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 7; i++) begin
      send(i + 1);
      repeat (i % 3) step();
    end
    end_layer("gap");
    check_q("gap", 7, '{1, 2, 3, 4, 5, 6, 7, 0}, '{0, 0, 1, 0, 0, 1, 0, 0});
    check("gap_cnt", 32'(dut.r_out_cnt), 1);

    // Asynchronous reset in the middle of a layer.
    start_layer(0, 1'b0, 1'b0, 3);
    send(5);
    send(-3);
    #2;
    reset = 1'b1;
    #1;
    check("ar_we", 32'(rslt_we), 0);
    check("ar_row", 32'(row_done), 0);
    check("ar_busy", 32'(busy), 0);
    start = 1'b0;
    step();
    reset = 1'b0;
    step();
    pass_through("ar_pt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
